deinterleaver: RTL and testbench

Block deinterleaver for the serial bit link. It undoes the row-in/column-out block interleaver at the receive end, restoring original bit order on `dout`. Incoming bits, already interleaved column-major over a ROWS×COLS matrix, are written into one bank of a ping-pong buffer in column order. The other, complete bank is read out row-major as a continuous burst.

---
 rtl/ilv_pkg.sv | 18 +
 rtl/ilv_pingpong_ram.sv | 31 +++
 rtl/deinterleaver.sv | 115 +++++++++++
 tb/tb_deinterleaver.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ilv_pkg.sv
// Geometry and read-FSM encoding shared by the interleaver and deinterleaver,
// so both ends of the link always agree on the block shape.
package ilv_pkg;
  localparam int ROWS_DEF = 8;
  localparam int COLS_DEF = 8;
  localparam int N_DEF    = ROWS_DEF * COLS_DEF;
  localparam int ADDR_W   = $clog2(N_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } rd_state_e;

  // Counter width that stays legal for a degenerate dimension of 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ilv_pingpong_ram.sv
// Two N-bit banks: one write port and one registered read port that returns 0
// when not enabled, so its output register can drive the serial output directly.
module ilv_pingpong_ram
  import ilv_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int AW = ADDR_W
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic          i_wr_bank,
  input  logic [AW-1:0] i_wr_addr,
  input  logic          i_wr_dat,
  input  logic          i_re,
  input  logic          i_rd_bank,
  input  logic [AW-1:0] i_rd_addr,
  output logic          o_rd_dat
);
  logic [N-1:0] r_mem [2];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_wr_bank][i_wr_addr] <= i_wr_dat;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)     o_rd_dat <= 1'b0;
    else if (i_re) o_rd_dat <= r_mem[i_rd_bank][i_rd_addr];
    else           o_rd_dat <= 1'b0;
  end
endmodule

// File: rtl/deinterleaver.sv
// Receive-side block deinterleaver: column-order writes into one ping-pong bank
// while the previously filled bank drains row-major as a gap-free burst.
module deinterleaver
  import ilv_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic clk2,
  input  logic rst,
  input  logic din,
  input  logic din_valid,
  output logic dout,
  output logic dout_valid,
  output logic dout_last
);
  localparam int N  = ROWS * COLS;
  localparam int AW = cnt_w(N);
  localparam int RW = cnt_w(ROWS);
  localparam int CW = cnt_w(COLS);

  logic [RW-1:0] r_wr_row;
  logic [CW-1:0] r_wr_col;
  logic          r_wb;
  rd_state_e     r_state;
  logic [AW-1:0] r_rd_addr;
  logic          r_rd_bank;
  logic          r_dout_valid;
  logic          r_dout_last;

  logic          w_row_end;
  logic          w_col_end;
  logic          w_swap;
  logic          w_rd_end;
  logic          w_re;
  logic [AW-1:0] w_wr_addr;
  logic          w_rd_dat;

  assign w_row_end = (r_wr_row == RW'(ROWS - 1));
  assign w_col_end = (r_wr_col == CW'(COLS - 1));
  assign w_swap    = din_valid & w_row_end & w_col_end;
  assign w_rd_end  = (r_rd_addr == AW'(N - 1));
  assign w_re      = (r_state == DRAIN);
  assign w_wr_addr = AW'(r_wr_row) * AW'(COLS) + AW'(r_wr_col);

  // Row index moves fastest: incoming bits arrive one column at a time.
  always_ff @(posedge clk2) begin
    if (rst) begin
      r_wr_row <= '0;
      r_wr_col <= '0;
      r_wb     <= 1'b0;
    end else if (din_valid) begin
      if (w_row_end) begin
        r_wr_row <= '0;
        r_wr_col <= w_col_end ? '0 : r_wr_col + 1'b1;
      end else begin
        r_wr_row <= r_wr_row + 1'b1;
      end
      if (w_swap) r_wb <= ~r_wb;
    end
  end

  // A swap landing on the final drain cycle chains straight into the next bank.
  always_ff @(posedge clk2) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rd_addr    <= '0;
      r_rd_bank    <= 1'b0;
      r_dout_valid <= 1'b0;
      r_dout_last  <= 1'b0;
    end else begin
      r_dout_valid <= w_re;
      r_dout_last  <= w_re & w_rd_end;
      case (r_state)
        IDLE: begin
          if (w_swap) begin
            r_state   <= DRAIN;
            r_rd_addr <= '0;
            r_rd_bank <= r_wb;
          end
        end
        DRAIN: begin
          if (w_rd_end) begin
            r_rd_addr <= '0;
            if (w_swap) r_rd_bank <= r_wb;
            else        r_state   <= IDLE;
          end else begin
            r_rd_addr <= r_rd_addr + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  ilv_pingpong_ram #(
    .N  (N),
    .AW (AW)
  ) u_ram (
    .i_clk     (clk2),
    .i_rst     (rst),
    .i_we      (din_valid),
    .i_wr_bank (r_wb),
    .i_wr_addr (w_wr_addr),
    .i_wr_dat  (din),
    .i_re      (w_re),
    .i_rd_bank (r_rd_bank),
    .i_rd_addr (r_rd_addr),
    .o_rd_dat  (w_rd_dat)
  );

  assign dout       = w_rd_dat;
  assign dout_valid = r_dout_valid;
  assign dout_last  = r_dout_last;
endmodule

// File: tb/tb_deinterleaver.sv
// Directed bench for the 8x8 deinterleaver: per-cycle output capture, then checks.
module tb_deinterleaver;
  localparam int N = 64;

  logic clk2 = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic dout, dout_valid, dout_last;

  int n_chk = 0;
  int n_err = 0;
  logic q_v[$];
  logic q_d[$];
  logic q_l[$];

  deinterleaver #(.ROWS(8), .COLS(8)) dut (
    .clk2       (clk2),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last)
  );

  always #5 clk2 = ~clk2;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input, then sample outputs 1 time unit after the edge.
  task automatic cyc(input logic d, input logic v);
    din = d;
    din_valid = v;
    @(posedge clk2);
    #1;
    q_v.push_back(dout_valid);
    q_d.push_back(dout);
    q_l.push_back(dout_last);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0);
  endtask

  task automatic clear();
    q_v.delete();
    q_d.delete();
    q_l.delete();
  endtask

  // Bit k of the block is p[63-k]; optional gap on every third cycle.
  task automatic send64(input logic [63:0] p, input bit gap, output int last_idx);
    int k = 0;
    while (k < N) begin
      if (gap && (q_v.size() % 3 == 2)) cyc(1'b1, 1'b0);
      else begin
        cyc(p[63-k], 1'b1);
        k++;
      end
    end
    last_idx = q_v.size() - 1;
  endtask

  task automatic scan(output logic [127:0] bits, output int nv, output int nl,
                      output int first, output bit contig, output bit quiet);
    int lastv = -1;
    bits = '0; nv = 0; nl = 0; first = -1; quiet = 1'b1;
    for (int i = 0; i < q_v.size(); i++) begin
      if (q_v[i]) begin
        bits = {bits[126:0], q_d[i]};
        if (first < 0) first = i;
        lastv = i;
        nv++;
      end else if (q_d[i] || q_l[i]) quiet = 1'b0;
      if (q_l[i]) begin
        nl++;
        if (nv % N != 0) quiet = 1'b0;
      end
    end
    contig = (nv > 0) && (lastv - first + 1 == nv);
  endtask

  task automatic check_run(input string tag, input logic [127:0] exp_bits, input int exp_nv,
                           input int exp_nl, input int exp_first);
    logic [127:0] bits;
    int nv, nl, first;
    bit contig, quiet;
    scan(bits, nv, nl, first, contig, quiet);
    chk({tag, ".bits"},   bits, exp_bits);
    chk({tag, ".nvalid"}, 128'(nv), 128'(exp_nv));
    chk({tag, ".nlast"},  128'(nl), 128'(exp_nl));
    chk({tag, ".first"},  128'(first), 128'(exp_first));
    chk({tag, ".contig"}, 128'(contig), 128'(1));
    chk({tag, ".quiet"},  128'(quiet), 128'(1));
  endtask

  initial begin
    int L;
    logic orig [640];
    logic outs[$];
    logic [63:0] got, exp;
    logic [127:0] bits;
    int nv, nl, first;
    bit contig, quiet;

    rst = 1'b1;
    idle(2);
    chk("reset.dout",  128'(dout), 128'(0));
    chk("reset.valid", 128'(dout_valid), 128'(0));
    chk("reset.last",  128'(dout_last), 128'(0));
    rst = 1'b0;

    clear();
    send64({8'hFF, 56'h0}, 1'b0, L);
    idle(N + 4);
    check_run("col", 128'(64'h8080808080808080), 64, 1, L + 1);

    clear();
    send64(64'h8080808080808080, 1'b0, L);
    idle(N + 4);
    check_run("row", 128'(64'hFF00000000000000), 64, 1, L + 1);

    clear();
    for (int i = 0; i < 2 * N; i++) cyc(1'(i % 2), 1'b1);
    idle(N + 4);
    check_run("alt", {2{64'h00FF00FF00FF00FF}}, 128, 2, N);

    clear();
    send64({8'hFF, 56'h0}, 1'b1, L);
    idle(N + 4);
    check_run("gap", 128'(64'h8080808080808080), 64, 1, L + 1);

    clear();
    repeat (30) cyc(1'b1, 1'b1);
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    rst = 1'b0;
    send64(64'h8080808080808080, 1'b0, L);
    idle(N + 4);
    check_run("rstblk", 128'(64'hFF00000000000000), 64, 1, L + 1);

    clear();
    send64({8'hFF, 56'h0}, 1'b0, L);
    idle(10);
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    chk("drainrst.valid", 128'(dout_valid), 128'(0));
    chk("drainrst.dout",  128'(dout), 128'(0));
    rst = 1'b0;
    idle(N + 4);
    scan(bits, nv, nl, first, contig, quiet);
    chk("drainrst.nvalid", 128'(nv), 128'(10));
    chk("drainrst.bits",   bits, 128'(10'b1000000010));
    chk("drainrst.nlast",  128'(nl), 128'(0));
    clear();
    send64(64'h8080808080808080, 1'b0, L);
    idle(N + 4);
    check_run("afterrst", 128'(64'hFF00000000000000), 64, 1, L + 1);

    // Loopback through a behavioural row-in/column-out interleaver.
    clear();
    for (int i = 0; i < 640; i++) orig[i] = 1'($urandom);
    for (int b = 0; b < 10; b++)
      for (int k = 0; k < N; k++)
        cyc(orig[b * N + (k % 8) * 8 + (k / 8)], 1'b1);
    idle(N + 4);
    scan(bits, nv, nl, first, contig, quiet);
    chk("loop.nvalid", 128'(nv), 128'(640));
    chk("loop.nlast",  128'(nl), 128'(10));
    chk("loop.first",  128'(first), 128'(N));
    chk("loop.contig", 128'(contig), 128'(1));
    chk("loop.quiet",  128'(quiet), 128'(1));
    for (int i = 0; i < q_v.size(); i++) if (q_v[i]) outs.push_back(q_d[i]);
    for (int b = 0; b < 10; b++) begin
      got = '0;
      exp = '0;
      for (int k = 0; k < N; k++) begin
        exp = {exp[62:0], orig[b * N + k]};
        if (b * N + k < outs.size()) got = {got[62:0], outs[b * N + k]};
        else got = {got[62:0], 1'bx};
      end
      chk($sformatf("loop.blk%0d", b), 128'(got), 128'(exp));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
